// File: rtl/mc_control.sv
// mc_control: multicycle MIPS control FSM (lw, sw, R-type, beq, addi, j); define MC_CONTROL_BNE_EN to add bne
module mc_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       i_or_d,
    output logic       alu_src_a,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctrl,
    output logic       illegal_op,
    output logic [3:0] state
);
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    state_t cur, nxt, s;
    logic is_bne, is_br, fn_ok;
    logic [2:0] fn_alu;

`ifdef MC_CONTROL_BNE_EN
    assign is_bne = opcode == 6'b000101;
`else
    assign is_bne = 1'b0;
`endif
    assign is_br = opcode == OP_BEQ || is_bne;

    // R-type funct to ALU operation; unknown functs fall back to add and are flagged
    always_comb begin
        fn_ok  = 1'b1;
        fn_alu = 3'b010;
        case (funct)
            6'b100000: fn_alu = 3'b010;
            6'b100010: fn_alu = 3'b110;
            6'b100100: fn_alu = 3'b000;
            6'b100101: fn_alu = 3'b001;
            6'b101010: fn_alu = 3'b111;
            default:   fn_ok  = 1'b0;
        endcase
    end

    // next-state selection; memory states wait on mem_ready, unused encodings recover to FETCH
    always_comb begin
        nxt = FETCH;
        case (cur)
            FETCH:   nxt = mem_ready ? DECODE : FETCH;
            DECODE:  nxt = (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
                           opcode == OP_R    ? EXECUTE :
                           is_br             ? BRANCH  :
                           opcode == OP_ADDI ? ADDIEX  :
                           opcode == OP_J    ? JUMP    : FETCH;
            MEMADR:  nxt = opcode == OP_SW ? MEMWR : MEMRD;
            MEMRD:   nxt = mem_ready ? MEMWB : MEMRD;
            MEMWR:   nxt = mem_ready ? FETCH : MEMWR;
            EXECUTE: nxt = fn_ok ? ALUWB : FETCH;
            ADDIEX:  nxt = ADDIWB;
            default: nxt = FETCH;
        endcase
    end

    // state register with synchronous reset back to FETCH
    always_ff @(posedge clk) begin
        cur <= reset ? FETCH : nxt;
    end

    // Moore output decode; reset presents FETCH with all write/enable strobes low
    always_comb begin
        s          = reset ? FETCH : cur;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        i_or_d     = 1'b0;
        alu_src_a  = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        pc_en      = 1'b0;
        pc_src     = 2'b00;
        alu_src_b  = 2'b00;
        alu_ctrl   = 3'b010;
        illegal_op = 1'b0;
        case (s)
            FETCH: begin
                alu_src_b = 2'b01;
                ir_write  = mem_ready & ~reset;
                pc_en     = mem_ready & ~reset;
            end
            DECODE: begin
                alu_src_b  = 2'b11;
                illegal_op = !(opcode == OP_LW || opcode == OP_SW || opcode == OP_R ||
                               is_br || opcode == OP_ADDI || opcode == OP_J);
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEMRD: i_or_d = 1'b1;
            MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            MEMWR: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
            end
            EXECUTE: begin
                alu_src_a  = 1'b1;
                alu_ctrl   = fn_alu;
                illegal_op = ~fn_ok;
            end
            ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_ctrl  = 3'b110;
                pc_src    = 2'b01;
                pc_en     = is_bne ? ~zero : zero;
            end
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            ADDIWB: reg_write = 1'b1;
            JUMP: begin
                pc_src = 2'b10;
                pc_en  = 1'b1;
            end
            default: ;
        endcase
    end

    assign state = s;
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed instruction sequences checked every cycle against an instruction-path model
module tb_mc_control;
    logic clk = 1'b0, reset, zero, mem_ready;
    logic [5:0] opcode, funct;
    logic mem_to_reg, reg_dst, i_or_d, alu_src_a, ir_write, mem_write, reg_write, pc_en, illegal_op;
    logic [1:0] pc_src, alu_src_b;
    logic [2:0] alu_ctrl;
    logic [3:0] state;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101, ADDI = 6'b001000, JMP = 6'b000010;
`ifdef MC_CONTROL_BNE_EN
    localparam bit BNE_EN = 1'b1;
`else
    localparam bit BNE_EN = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] st;
        logic m2r, rdst, iord, asa, irw, mw, rw, pce;
        logic [1:0] pcs, asb;
        logic [2:0] alu;
        logic ill;
    } outs_t;

    int vectors = 0, miscompares = 0, pos = 0, cyc_n = 0;
    outs_t tr[$];

    mc_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .i_or_d(i_or_d), .alu_src_a(alu_src_a),
        .ir_write(ir_write), .mem_write(mem_write), .reg_write(reg_write), .pc_en(pc_en),
        .pc_src(pc_src), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .illegal_op(illegal_op),
        .state(state)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] alu_of(input logic [5:0] fn, output logic ok);
        ok = 1'b1;
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default: begin ok = 1'b0; return 3'b010; end
        endcase
    endfunction

    function automatic bit fn_good(input logic [5:0] fn);
        logic ok;
        logic [3:0] a;
        a = alu_of(fn, ok);
        return ok && a[3] == 1'b0;
    endfunction

    function automatic bit is_branch(input logic [5:0] op);
        return op == BEQ || (BNE_EN && op == BNE);
    endfunction

    // number of states an instruction walks through, FETCH included
    function automatic int path_len(input logic [5:0] op, input logic [5:0] fn);
        if (op == LW) return 5;
        if (op == SW || op == ADDI) return 4;
        if (op == RT) return fn_good(fn) ? 4 : 3;
        if (is_branch(op) || op == JMP) return 3;
        return 2;
    endfunction

    function automatic int path_at(input logic [5:0] op, input logic [5:0] fn, input int i);
        int lw_p[5] = '{0, 1, 2, 3, 4};
        int sw_p[4] = '{0, 1, 2, 5};
        int r_p[4]  = '{0, 1, 6, 7};
        int ai_p[4] = '{0, 1, 9, 10};
        if (i < 2) return i;
        if (op == LW) return lw_p[i];
        if (op == SW) return sw_p[i];
        if (op == RT) return r_p[i];
        if (op == ADDI) return ai_p[i];
        if (is_branch(op)) return 8;
        if (op == JMP) return 11;
        return 0;
    endfunction

    function automatic outs_t model_out(input int st, input logic [5:0] op, input logic [5:0] fn,
                                        input logic z, input logic mr, input logic rst);
        outs_t o;
        logic ok;
        logic [3:0] a;
        o = '0;
        o.alu = 3'b010;
        if (rst || st == 0) begin
            o.asb = 2'b01;
            o.irw = mr & ~rst;
            o.pce = mr & ~rst;
            return o;
        end
        o.st = 4'(st);
        case (st)
            1: begin o.asb = 2'b11; o.ill = path_len(op, 6'b100000) == 2; end
            2: begin o.asa = 1'b1; o.asb = 2'b10; end
            3: o.iord = 1'b1;
            4: begin o.m2r = 1'b1; o.rw = 1'b1; end
            5: begin o.iord = 1'b1; o.mw = 1'b1; end
            6: begin a = alu_of(fn, ok); o.asa = 1'b1; o.alu = a[2:0]; o.ill = ~ok; end
            7: begin o.rdst = 1'b1; o.rw = 1'b1; end
            8: begin o.asa = 1'b1; o.alu = 3'b110; o.pcs = 2'b01; o.pce = (op == BNE) ? ~z : z; end
            9: begin o.asa = 1'b1; o.asb = 2'b10; end
            10: o.rw = 1'b1;
            11: begin o.pcs = 2'b10; o.pce = 1'b1; end
            default: ;
        endcase
        return o;
    endfunction

    // model advance: step along the instruction path, hold on memory waits, restart on reset
    always @(posedge clk) begin
        int st;
        st = path_at(opcode, funct, pos);
        if (reset) pos <= 0;
        else if ((st == 0 || st == 3 || st == 5) && !mem_ready) pos <= pos;
        else pos <= (pos + 1 >= path_len(opcode, funct)) ? 0 : pos + 1;
    end

    // per-cycle comparison of every output against the model
    always @(negedge clk) begin
        outs_t g, e;
        g = {state, mem_to_reg, reg_dst, i_or_d, alu_src_a, ir_write, mem_write, reg_write, pc_en,
             pc_src, alu_src_b, alu_ctrl, illegal_op};
        e = model_out(path_at(opcode, funct, pos), opcode, funct, zero, mem_ready, reset);
        vectors++;
        cyc_n++;
        if (g !== e) begin
            miscompares++;
            $display("FAIL cycle %0d op=%b fn=%b: got %h want %h", cyc_n, opcode, funct, g, e);
        end
        tr.push_back(g);
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic mr);
        mem_ready = mr;
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [5:0] op, input logic [5:0] fn, input logic z);
        opcode = op;
        funct = fn;
        zero = z;
        tr.delete();
    endtask

    task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z, input int n);
        start(op, fn, z);
        repeat (n) cyc(1'b1);
    endtask

    initial begin
        int lw_seq[5] = '{0, 1, 2, 3, 4};
        int fs_seq[6] = '{0, 0, 0, 1, 9, 10};
        int k;
        reset = 1'b1;
        opcode = RT;
        funct = 6'b100000;
        zero = 1'b0;
        mem_ready = 1'b0;
        repeat (2) cyc(1'b1);
        reset = 1'b0;
        check("reset_state", state, 0);

        run(LW, 6'b0, 1'b0, 5);
        for (int i = 0; i < 5; i++) begin
            check("lw_state", tr[i].st, lw_seq[i]);
            check("lw_reg_write", tr[i].rw, i == 4);
        end
        check("lw_end", state, 0);

        start(SW, 6'b0, 1'b0);
        repeat (3) cyc(1'b1);
        repeat (3) cyc(1'b0);
        cyc(1'b1);
        k = 0;
        foreach (tr[i]) k += tr[i].mw;
        check("sw_mw_count", k, 4);
        check("sw_mw_run", tr[3].mw & tr[4].mw & tr[5].mw & tr[6].mw, 1);
        check("sw_end", state, 0);

        run(RT, 6'b101010, 1'b0, 4);
        check("slt_alu", tr[2].alu, 3'b111);
        run(RT, 6'b100000, 1'b0, 4);
        run(RT, 6'b100010, 1'b0, 4);
        check("sub_alu", tr[2].alu, 3'b110);
        run(RT, 6'b100100, 1'b0, 4);
        run(RT, 6'b100101, 1'b0, 4);

        run(RT, 6'b000111, 1'b0, 3);
        check("badfn_ill", tr[2].ill, 1);
        check("badfn_end", state, 0);
        k = 0;
        foreach (tr[i]) k += tr[i].rw;
        check("badfn_rw", k, 0);

        run(BEQ, 6'b0, 1'b1, 3);
        check("beq_z1_pce", tr[2].pce, 1);
        check("beq_z1_pcs", tr[2].pcs, 1);
        run(BEQ, 6'b0, 1'b0, 3);
        check("beq_z0_pce", tr[2].pce, 0);

        run(ADDI, 6'b0, 1'b0, 4);
        run(JMP, 6'b0, 1'b0, 3);
        check("j_pcs", tr[2].pcs, 2);
        run(6'b111111, 6'b0, 1'b0, 2);
        check("badop_ill", tr[1].ill, 1);
        check("badop_end", state, 0);

        if (BNE_EN) begin
            run(BNE, 6'b0, 1'b0, 3);
            check("bne_pce", tr[2].pce, 1);
            check("bne_state", tr[2].st, 8);
        end else begin
            run(BNE, 6'b0, 1'b0, 2);
            check("bne_ill", tr[1].ill, 1);
        end

        start(ADDI, 6'b0, 1'b0);
        repeat (2) cyc(1'b0);
        repeat (4) cyc(1'b1);
        for (int i = 0; i < 6; i++) check("fstall_state", tr[i].st, fs_seq[i]);
        check("fstall_irw", tr[0].irw, 0);
        check("fstall_irw_go", tr[2].irw, 1);

        start(LW, 6'b0, 1'b0);
        repeat (3) cyc(1'b1);
        repeat (2) cyc(1'b0);
        reset = 1'b1;
        cyc(1'b0);
        reset = 1'b0;
        check("rst_memrd_end", state, 0);
        check("rst_memrd_prev", tr[4].st, 3);
        k = 0;
        foreach (tr[i]) k += tr[i].mw + tr[i].rw;
        check("rst_memrd_wr", k, 0);

        start(SW, 6'b0, 1'b0);
        repeat (3) cyc(1'b1);
        cyc(1'b0);
        reset = 1'b1;
        cyc(1'b0);
        reset = 1'b0;
        check("rst_memwr_mw_before", tr[3].mw, 1);
        check("rst_memwr_mw_during", tr[4].mw, 0);
        check("rst_memwr_end", state, 0);

        run(LW, 6'b0, 1'b0, 5);
        check("post_rst_lw", tr[4].st, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
